// File: rtl/muldiv_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : muldiv_seq_pkg
// Brief   : State and opcode encodings shared by the sequential mul/div unit.
// Revision: 1.0 - initial release
// ============================================================================
package muldiv_seq_pkg;

   // Controller states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Operation select captured with start
   localparam logic OP_MULTU = 1'b0;
   localparam logic OP_DIVU  = 1'b1;

endpackage : muldiv_seq_pkg
`default_nettype wire

// File: rtl/f_add_Nbit.sv
`default_nettype none
// ============================================================================
// Module  : f_add_Nbit
// Brief   : DW-bit ripple-carry adder with carry in and carry out.
// Revision: 1.0 - initial release
// ============================================================================
module f_add_Nbit #(
   parameter int DW = 32
) (
   input  logic [DW-1:0] a_i,
   input  logic [DW-1:0] b_i,
   input  logic          cin_i,
   output logic [DW-1:0] sum_o,
   output logic          cout_o
);

   logic [DW:0] w_carry;

   assign w_carry[0] = cin_i;

   // One full adder per bit, carry rippling from LSB to MSB
   for (genvar i = 0; i < DW; i++) begin : g_bit
      assign sum_o[i]     = a_i[i] ^ b_i[i] ^ w_carry[i];
      assign w_carry[i+1] = (a_i[i] & b_i[i]) | (w_carry[i] & (a_i[i] ^ b_i[i]));
   end

   assign cout_o = w_carry[DW];

endmodule : f_add_Nbit
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module  : muldiv_seq
// Brief   : Multi-cycle unsigned multiply (shift-add) / divide (restoring)
//           sharing a single ripple adder, one iteration per clock.
// Revision: 1.0 - initial release
// ============================================================================
module muldiv_seq
   import muldiv_seq_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          op,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] hi,
   output logic [DW-1:0] lo
);

   localparam int            CW         = $clog2(DW);
   localparam logic [CW-1:0] C_CNT_LAST = CW'(DW - 1);

   state_t        state_q;
   logic          busy_q;
   logic          done_q;
   logic          op_q;
   logic [CW-1:0] cnt_q;
   logic [DW-1:0] m_q;
   logic [DW-1:0] hi_q;
   logic [DW-1:0] lo_q;
   logic [DW-1:0] hi_d;
   logic [DW-1:0] lo_d;

   logic [DW-1:0] w_rem_shift;
   logic [DW-1:0] w_add_a;
   logic [DW-1:0] w_add_b;
   logic          w_add_cin;
   logic [DW-1:0] w_add_sum;
   logic          w_add_cout;

   // Adder operand muxes: divide subtracts M from the shifted remainder,
   // multiply conditionally adds M into the upper half
   always_comb begin
      w_rem_shift = {hi_q[DW-2:0], lo_q[DW-1]};
      if (op_q == OP_DIVU) begin
         w_add_a   = w_rem_shift;
         w_add_b   = ~m_q;
         w_add_cin = 1'b1;
      end else begin
         w_add_a   = hi_q;
         w_add_b   = lo_q[0] ? m_q : '0;
         w_add_cin = 1'b0;
      end
   end

   f_add_Nbit #(.DW(DW)) u_add (
      .a_i    (w_add_a),
      .b_i    (w_add_b),
      .cin_i  (w_add_cin),
      .sum_o  (w_add_sum),
      .cout_o (w_add_cout)
   );

   // Next hi/lo for one iteration; the dropped MSB of the remainder (hi[DW-1])
   // forces the subtract to be kept, since the true remainder exceeds M
   always_comb begin
      if (op_q == OP_DIVU) begin
         if (w_add_cout | hi_q[DW-1]) begin
            hi_d = w_add_sum;
            lo_d = {lo_q[DW-2:0], 1'b1};
         end else begin
            hi_d = w_rem_shift;
            lo_d = {lo_q[DW-2:0], 1'b0};
         end
      end else begin
         hi_d = {w_add_cout, w_add_sum[DW-1:1]};
         lo_d = {w_add_sum[0], lo_q[DW-1:1]};
      end
   end

   // Controller, iteration counter and result shift registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         op_q    <= OP_MULTU;
         cnt_q   <= '0;
         m_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= RUN;
                  busy_q  <= 1'b1;
                  op_q    <= op;
                  m_q     <= (op == OP_DIVU) ? b : a;
                  hi_q    <= '0;
                  lo_q    <= (op == OP_DIVU) ? a : b;
                  cnt_q   <= '0;
               end
            end
            RUN: begin
               hi_q  <= hi_d;
               lo_q  <= lo_d;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == C_CNT_LAST) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule : muldiv_seq
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_muldiv_seq
// Brief   : Scoreboard bench for muldiv_seq with directed MULTU/DIVU vectors.
// Revision: 1.0 - initial release
// ============================================================================
module tb_muldiv_seq;

   localparam int DW = 32;

   typedef struct packed {
      logic [DW-1:0] hi;
      logic [DW-1:0] lo;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          op;
   logic [DW-1:0] a;
   logic [DW-1:0] b;
   logic          busy;
   logic          done;
   logic [DW-1:0] hi;
   logic [DW-1:0] lo;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   muldiv_seq #(.DW(DW)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Monitor: compare each done pulse against the oldest expected result
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got hi=0x%0h lo=0x%0h, expected no result", hi, lo);
            end else begin
               e = sb_q.pop_front();
               chk("result_hi", 64'(hi), 64'(e.hi));
               chk("result_lo", 64'(lo), 64'(e.lo));
            end
         end
      end
   end

   // Returns number of edges until done is seen (bounded)
   task automatic wait_done(output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (done !== 1'b1 && n < 100);
      if (done !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got no done after %0d cycles, expected done", n);
      end
   endtask

   task automatic run_op(input string name, input logic o, input logic [DW-1:0] av,
                         input logic [DW-1:0] bv, input logic [DW-1:0] eh,
                         input logic [DW-1:0] el);
      int n;
      sb_q.push_back('{hi: eh, lo: el});
      start = 1'b1; op = o; a = av; b = bv;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk({name, "_busy_run"}, 64'(busy), 64'd1);
      wait_done(n);
      chk({name, "_latency"}, 64'(n), 64'(DW));
      @(posedge clk);
      #1;
      chk({name, "_busy_after"}, 64'(busy), 64'd0);
      chk({name, "_hold_hi"}, 64'(hi), 64'(eh));
      chk({name, "_hold_lo"}, 64'(lo), 64'(el));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_hi",   64'(hi),   64'd0);
      chk("reset_lo",   64'(lo),   64'd0);

      run_op("mul_7x6",  1'b0, 32'd7, 32'd6, 32'd0, 32'd42);
      run_op("mul_max",  1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      run_op("div_100_7", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14);
      run_op("div_msb_3", 1'b1, 32'h8000_0000, 32'd3, 32'd2, 32'h2AAA_AAAA);
      run_op("div_by_0", 1'b1, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF);

      // Starts while busy are ignored; start in following IDLE cycle accepted
      sb_q.push_back('{hi: 32'd0, lo: 32'h0001_0000});
      start = 1'b1; op = 1'b0; a = 32'h1000; b = 32'h10;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      start = 1'b1; op = 1'b1; a = 32'd9; b = 32'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(n);
      chk("ignore_run_latency", 64'(n + 5), 64'(DW));
      start = 1'b1; op = 1'b1; a = 32'd77; b = 32'd7;
      @(posedge clk);
      #1;
      chk("ignore_done_busy", 64'(busy), 64'd0);
      chk("ignore_done_lo",   64'(lo),   64'h0001_0000);
      sb_q.push_back('{hi: 32'd0, lo: 32'd10});
      op = 1'b1; a = 32'd50; b = 32'd5;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("accept_idle_busy", 64'(busy), 64'd1);
      wait_done(n);
      chk("accept_idle_latency", 64'(n), 64'(DW));
      @(posedge clk);
      #1;

      // Reset mid-operation discards the in-flight result
      start = 1'b1; op = 1'b0; a = 32'd11; b = 32'd13;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_hi",   64'(hi),   64'd0);
      chk("abort_lo",   64'(lo),   64'd0);
      run_op("mul_3x5", 1'b0, 32'd3, 32'd5, 32'd0, 32'd15);

      repeat (2) @(posedge clk);
      #1;
      chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_muldiv_seq
`default_nettype wire
